// File: rtl/seg_display_monitor.sv
// Receiver for the multiplexed seven-segment bus: filters scanned anode/segment
// lines, decodes each stable digit back to a hex nibble and reports full frames.
module seg_display_monitor #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        changed,
    output logic        seg_err,
    output logic        an_err
);

    localparam logic [7:0] N = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    logic [3:0]  an_q, an_p;
    logic [6:0]  seg_q, seg_p;
    logic        dp_q, dp_p;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dps_q, dps_d, blank_q, blank_d, seen_q, seen_d;
    logic [23:0] snap_q, snap_d;
    logic        snap_vld_q, snap_vld_d;
    logic        frame_done_q, frame_done_d, changed_q, changed_d;
    logic        seg_err_q, seg_err_d, an_err_q, an_err_d;

    logic        same, hit, onehot, cap, legal, is_blank;
    logic [1:0]  pos;
    logic [3:0]  nib;

    always_comb begin
        same  = {an_q, seg_q, dp_q} == {an_p, seg_p, dp_p};
        cnt_d = same ? ((cnt_q >= N) ? N : cnt_q + 8'd1) : 8'd1;
        // a saturated counter on an unchanged sample is the same interval, not a new hit
        hit   = (cnt_d == N) && !(same && cnt_q == N);

        onehot = 1'b1;
        pos    = 2'd0;
        case (an_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: onehot = 1'b0;
        endcase

        legal    = 1'b1;
        is_blank = 1'b0;
        nib      = 4'h0;
        case (seg_q)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h7F: begin legal = 1'b0; is_blank = 1'b1; end
            default: legal = 1'b0;
        endcase

        cap = 1'b0;
        if (!onehot) begin
            state_d = IDLE;
        end else if (hit) begin
            cap     = 1'b1;
            state_d = HELD;
        end else if (state_q == HELD && same) begin
            state_d = HELD;
        end else begin
            state_d = COUNT;
        end
        an_err_d = !onehot && (an_q != 4'hF) && hit;

        frame_done_d = (seen_q == 4'hF);
        changed_d    = frame_done_d && (!snap_vld_q || ({digits_q, dps_q, blank_q} != snap_q));
        snap_d       = frame_done_d ? {digits_q, dps_q, blank_q} : snap_q;
        snap_vld_d   = snap_vld_q | frame_done_d;

        // the frame clear comes first so a coincident capture survives it
        seen_d    = frame_done_d ? 4'h0 : seen_q;
        digits_d  = digits_q;
        dps_d     = dps_q;
        blank_d   = blank_q;
        seg_err_d = 1'b0;
        if (cap) begin
            if (legal || is_blank) begin
                if (legal) digits_d[{pos, 2'b00} +: 4] = nib;
                blank_d[pos] = is_blank;
                dps_d[pos]   = !dp_q;
                seen_d[pos]  = 1'b1;
            end else begin
                seg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_p         <= 4'hF;
            seg_p        <= 7'h7F;
            dp_p         <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            digits_q     <= 16'h0;
            dps_q        <= 4'h0;
            blank_q      <= 4'hF;
            seen_q       <= 4'h0;
            snap_q       <= 24'h0;
            snap_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            seg_err_q    <= 1'b0;
            an_err_q     <= 1'b0;
        end else begin
            an_q         <= an;
            seg_q        <= seg;
            dp_q         <= dp;
            an_p         <= an_q;
            seg_p        <= seg_q;
            dp_p         <= dp_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            dps_q        <= dps_d;
            blank_q      <= blank_d;
            seen_q       <= seen_d;
            snap_q       <= snap_d;
            snap_vld_q   <= snap_vld_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
            seg_err_q    <= seg_err_d;
            an_err_q     <= an_err_d;
        end
    end

    assign digits     = digits_q;
    assign dps        = dps_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;
    assign changed    = changed_q;
    assign seg_err    = seg_err_q;
    assign an_err     = an_err_q;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed bench for seg_display_monitor: scans, glitches, illegal patterns,
// blanking and asynchronous reset, with pulse counters sampled on the falling edge.
module tb_seg_display_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        dp = 1'b1;
    logic [15:0] digits;
    logic [3:0]  dps, blank;
    logic        frame_done, changed, seg_err, an_err;

    int checks = 0;
    int errors = 0;
    int fd_n = 0, ch_n = 0, se_n = 0, ae_n = 0;

    seg_display_monitor #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
        .digits(digits), .dps(dps), .blank(blank),
        .frame_done(frame_done), .changed(changed),
        .seg_err(seg_err), .an_err(an_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_n++;
        if (changed)    ch_n++;
        if (seg_err)    se_n++;
        if (an_err)     ae_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_dps", 32'(dps), 32'h0);
        chk("rst_pulses", 32'({frame_done, changed, seg_err, an_err}), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // scan 1, with exact capture latency on position 0
        an = 4'b1110; seg = 7'h79; dp = 1'b1;
        repeat (4) @(negedge clk);
        chk("lat_before", 32'(digits[3:0]), 32'h0);
        @(negedge clk);
        chk("lat_at", 32'(digits[3:0]), 32'h1);
        repeat (3) @(negedge clk);
        drive(4'b1101, 7'h24, 1'b1, 8);
        drive(4'b1011, 7'h30, 1'b1, 8);
        chk("no_frame_3of4", 32'(fd_n), 32'd0);
        drive(4'b0111, 7'h19, 1'b1, 8);
        chk("s1_digits", 32'(digits), 32'h4321);
        chk("s1_blank", 32'(blank), 32'h0);
        chk("s1_dps", 32'(dps), 32'h0);
        chk("s1_frame", 32'(fd_n), 32'd1);
        chk("s1_changed", 32'(ch_n), 32'd1);

        // identical scan: frame but no change
        drive(4'b1110, 7'h79, 1'b1, 8);
        drive(4'b1101, 7'h24, 1'b1, 8);
        drive(4'b1011, 7'h30, 1'b1, 8);
        drive(4'b0111, 7'h19, 1'b1, 8);
        chk("s2_frame", 32'(fd_n), 32'd2);
        chk("s2_changed", 32'(ch_n), 32'd1);
        chk("s2_digits", 32'(digits), 32'h4321);

        // short hold on position 1 with glitches between digits
        drive(4'b1110, 7'h79, 1'b1, 8);
        drive(4'b1111, 7'h7F, 1'b1, 2);
        drive(4'b1101, 7'h12, 1'b1, 3);
        drive(4'b1111, 7'h7F, 1'b1, 2);
        drive(4'b1011, 7'h30, 1'b1, 8);
        drive(4'b0111, 7'h19, 1'b1, 8);
        chk("short_no_frame", 32'(fd_n), 32'd2);
        chk("short_seen", 32'(dut.seen_q), 32'hD);
        chk("short_digits", 32'(digits), 32'h4321);

        // illegal anode pattern held 6 cycles
        drive(4'b1100, 7'h40, 1'b1, 6);
        chk("an_err_once", 32'(ae_n), 32'd1);
        chk("an_err_nocap", 32'(digits), 32'h4321);

        // illegal glyph on position 0
        drive(4'b1110, 7'h55, 1'b1, 8);
        chk("seg_err_once", 32'(se_n), 32'd1);
        chk("seg_err_nib", 32'(digits[3:0]), 32'h1);
        chk("seg_err_seen", 32'(dut.seen_q), 32'hD);

        // blank with dp lit on position 2
        drive(4'b1011, 7'h7F, 1'b0, 8);
        chk("blank2", 32'(blank), 32'h4);
        chk("dps2", 32'(dps), 32'h4);
        chk("blank_nib", 32'(digits), 32'h4321);

        // position 1 completes the frame; contents differ from the last snapshot
        drive(4'b1101, 7'h24, 1'b1, 8);
        chk("s3_frame", 32'(fd_n), 32'd3);
        chk("s3_changed", 32'(ch_n), 32'd2);

        // reset during the third digit's count
        drive(4'b1110, 7'h79, 1'b1, 8);
        drive(4'b1101, 7'h24, 1'b1, 8);
        drive(4'b1011, 7'h30, 1'b1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_blank", 32'(blank), 32'hF);
        chk("arst_dps", 32'(dps), 32'h0);
        chk("arst_pulses", 32'({frame_done, changed, seg_err, an_err}), 32'h0);
        chk("arst_seen", 32'(dut.seen_q), 32'h0);
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        drive(4'b1110, 7'h40, 1'b1, 8);
        drive(4'b1101, 7'h12, 1'b1, 8);
        drive(4'b1011, 7'h00, 1'b1, 8);
        chk("post_no_frame", 32'(fd_n), 32'd3);
        drive(4'b0111, 7'h0E, 1'b1, 8);
        chk("post_frame", 32'(fd_n), 32'd4);
        chk("post_changed", 32'(ch_n), 32'd3);
        chk("post_digits", 32'(digits), 32'hF850);
        chk("post_blank", 32'(blank), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
